// File: rtl/led_display_pkg.sv
// Shared types and helpers for the LED panel PWM/BCM generator.
package led_display_pkg;

    typedef enum logic {
        PWM_MODE = 1'b0,
        BCM_MODE = 1'b1
    } mod_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } bcm_state_t;

    // Plane index width; never zero so small depths still elaborate.
    function automatic int plane_width(input int bit_depth);
        return (bit_depth > 1) ? $clog2(bit_depth) : 1;
    endfunction

endpackage

// File: rtl/led_display_bcm_timer.sv
// Modulation timebase: prescaler, tick counter and BCM plane index.
// Outputs are next-cycle values so the top can register its drive with no lag.
module led_display_bcm_timer
    import led_display_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int TICK_DIV  = 4,
    parameter int PLANE_W   = plane_width(BIT_DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 n_reset_in,
    input  logic                 run,
    output logic [BIT_DEPTH-1:0] cnt_nxt,
    output logic [PLANE_W-1:0]   plane_nxt,
    output logic                 last_tick
);

    localparam int                   PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [BIT_DEPTH-1:0] CNT_LAST = BIT_DEPTH'((1 << BIT_DEPTH) - 2);

    logic [PRE_W-1:0]     pre, pre_nxt;
    logic [BIT_DEPTH-1:0] cnt, cnt_p1;
    logic                 tick;

    assign tick      = run && (pre == PRE_LAST);
    assign last_tick = tick && (cnt == CNT_LAST);

    // Counters sit at zero whenever the generator is not running.
    always_comb begin
        pre_nxt = '0;
        cnt_nxt = '0;
        if (run) begin
            if (!tick) begin
                pre_nxt = pre + PRE_W'(1);
                cnt_nxt = cnt;
            end else if (!last_tick) begin
                cnt_nxt = cnt + BIT_DEPTH'(1);
            end
        end
    end

    // Plane p spans ticks [2^p-1, 2^(p+1)-2], i.e. the MSB index of cnt+1.
    assign cnt_p1 = cnt_nxt + BIT_DEPTH'(1);

    always_comb begin
        plane_nxt = '0;
        for (int b = 0; b < BIT_DEPTH; b++)
            if (cnt_p1[b]) plane_nxt = PLANE_W'(b);
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            pre <= '0;
            cnt <= '0;
        end else begin
            pre <= pre_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/led_display_bcm_gen.sv
// Multi-channel PWM/BCM drive generator with double-buffered levels applied at period start.
// Optional: define GAMMA_CORRECTION_EN to square captured levels ((L*L)>>BIT_DEPTH, full scale kept).
module led_display_bcm_gen
    import led_display_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int NUM_CHANNELS = 6,
    parameter int BIT_DEPTH    = 8,
    parameter int TICK_DIV     = 4
) (
    input  logic                              clk_in,
    input  logic                              n_reset_in,
    input  logic                              enable_in,
    input  logic                              mode_in,
    input  logic [NUM_CHANNELS*BIT_DEPTH-1:0] level_in,
    input  logic                              level_valid_in,
    output logic                              level_ready_out,
    output logic [NUM_CHANNELS-1:0]           pwm_out,
    output logic [plane_width(BIT_DEPTH)-1:0] bit_plane_out,
    output logic                              period_start_out,
    output logic                              busy_out
);

    localparam int PLANE_W = plane_width(BIT_DEPTH);

    if (BIT_DEPTH < 2 || TICK_DIV < 1 || SYS_CLK_FREQ < 1) begin : g_param_check
        $error("led_display_bcm_gen: invalid parameter set");
    end

    function automatic logic [BIT_DEPTH-1:0] gamma_map(input logic [BIT_DEPTH-1:0] lvl);
`ifdef GAMMA_CORRECTION_EN
        logic [2*BIT_DEPTH-1:0] sq;
        sq = {{BIT_DEPTH{1'b0}}, lvl} * {{BIT_DEPTH{1'b0}}, lvl};
        return (&lvl) ? lvl : BIT_DEPTH'(sq >> BIT_DEPTH);
`else
        return lvl;
`endif
    endfunction

    bcm_state_t                             state;
    mod_mode_t                              mode_q, mode_nxt;
    logic [NUM_CHANNELS-1:0][BIT_DEPTH-1:0] active, pending, act_nxt, level_cap;
    logic                                   pending_full, accept, load, last_tick;
    logic [BIT_DEPTH-1:0]                   cnt_nxt;
    logic [PLANE_W-1:0]                     plane_nxt;
    logic [NUM_CHANNELS-1:0]                drive;

    assign load            = (state == ST_LOAD);
    assign level_ready_out = !pending_full;
    assign accept          = level_valid_in && !pending_full;
    assign mode_nxt        = load ? mod_mode_t'(mode_in) : mode_q;
    assign act_nxt         = (load && pending_full) ? pending : active;

    led_display_bcm_timer #(
        .BIT_DEPTH (BIT_DEPTH),
        .TICK_DIV  (TICK_DIV),
        .PLANE_W   (PLANE_W)
    ) u_timer (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .run        (state == ST_RUN),
        .cnt_nxt    (cnt_nxt),
        .plane_nxt  (plane_nxt),
        .last_tick  (last_tick)
    );

    // Drive is evaluated on next-cycle counter/level/mode so pwm_out can be registered.
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign level_cap[i] = gamma_map(level_in[i*BIT_DEPTH +: BIT_DEPTH]);
        assign drive[i]     = (mode_nxt == BCM_MODE) ? act_nxt[i][plane_nxt]
                                                     : (cnt_nxt < act_nxt[i]);
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            if (load) active <= act_nxt;
            if (accept) begin
                pending      <= level_cap;
                pending_full <= 1'b1;
            end else if (load) begin
                pending_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state            <= ST_IDLE;
            mode_q           <= PWM_MODE;
            pwm_out          <= '0;
            bit_plane_out    <= '0;
            period_start_out <= 1'b0;
            busy_out         <= 1'b0;
        end else begin
            period_start_out <= 1'b0;
            pwm_out          <= '0;
            bit_plane_out    <= '0;
            if (!enable_in) begin
                state    <= ST_IDLE;
                busy_out <= 1'b0;
            end else begin
                busy_out <= 1'b1;
                unique case (state)
                    ST_IDLE: begin
                        state            <= ST_LOAD;
                        period_start_out <= 1'b1;
                    end
                    ST_LOAD, ST_RUN: begin
                        if (last_tick) begin
                            state            <= ST_LOAD;
                            period_start_out <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            mode_q  <= mode_nxt;
                            pwm_out <= drive;
                            if (mode_nxt == BCM_MODE) bit_plane_out <= plane_nxt;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
